data_mem_arbiter: RTL and testbench
===================================

DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

Interface
REQ-001 Parameter MEM_BYTES, default 256: size in bytes of the attached DataMemory.
REQ-002 Port clk, input, 1: single clock; all state changes on posedge.
REQ-003 Port rst_n, input, 1: reset, asynchronous and active-low.
REQ-004 Ports ReqN_Valid/ReqN_Ready, 1 bit each, N=0,1: requester handshake (Valid in, Ready out).
REQ-005 Ports ReqN_Write, input, 1: 1 = store, 0 = load.
REQ-006 Ports ReqN_Op, input, 3: MemOp encoding 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu.
REQ-007 Ports ReqN_Addr and ReqN_WData, input, 32 each: byte address and store data.
REQ-008 Ports RspN_Valid (1), RspN_RData (32) and RspN_Err (1), outputs: response pulse, load data and error flag.
REQ-009 Ports MemOp (3), DataAddr (32), WriteData (32), MemRead (1) and MemWrite (1), outputs: DataMemory drive.
REQ-010 Port MemReadDataOut, input, 32: DataMemory read data, valid the cycle after the access edge.

Function
REQ-011 States SHALL be IDLE, ISSUE, WAIT and RESP.
REQ-012 IDLE: ReqN_Ready SHALL be high only for the granted port; no port is granted when no Valid is high.
REQ-013 Arbitration SHALL be round-robin: with both Valid high, grant the port not granted last; LastGrant resets to 1, so Req0 wins the first tie.
REQ-014 A transfer SHALL occur at the edge where ReqN_Valid and ReqN_Ready are both high; request fields are latched into internal registers at that edge.
REQ-015 Error check at acceptance SHALL flag any of:
- Op not in {000, 001, 010, 100, 101};
- halfword with Addr[0]=1;
- word with Addr[1:0]!=0;
- Addr + access bytes > MEM_BYTES.
REQ-016 Accepted without error: go to ISSUE; DataMemory outputs are registered; MemRead=!Write, MemWrite=Write, for exactly one cycle.
REQ-017 Accepted with error: go directly to RESP; MemRead and MemWrite stay 0 throughout.
REQ-018 ISSUE, store: go to RESP.
REQ-019 ISSUE, load: go to WAIT.
REQ-020 WAIT: capture MemReadDataOut into the RData register at the cycle-end edge, then go to RESP.
REQ-021 RESP: RspN_Valid SHALL be high for one cycle on the granted port only, with RspN_Err set accordingly.
REQ-022 RspN_RData SHALL be the captured data for loads and 0 for stores or errors.
REQ-023 RESP SHALL always return to IDLE.
REQ-024 Latency, acceptance edge E0 to response pulse:
- load: cycle E2-E3;
- store: cycle E1-E2;
- error: cycle E0-E1.
REQ-025 Ready SHALL be low in all states except IDLE; at most one outstanding access.
REQ-026 Outside ISSUE, MemRead and MemWrite SHALL be 0 and MemOp, DataAddr and WriteData SHALL hold their last values.
REQ-027 Deasserting Valid before acceptance SHALL be legal; nothing is latched.
REQ-028 The granted port's fields SHALL be used; the losing port's fields SHALL be ignored while its Valid is held.
REQ-029 LastGrant SHALL update at every acceptance, including errored ones.

Reset
REQ-030 rst_n low SHALL immediately force:
- state IDLE and LastGrant=1;
- all Ready, Rsp and Mem strobes to 0;
- MemOp, DataAddr, WriteData and RData to 0.
REQ-031 Reset mid-access SHALL abort the access with no response; an already-clocked write is not undone.

Verification
REQ-032 Req0 sw 0x11223344 to 0x10, then lw 0x10 -> store Rsp0 at E1-E2; load Rsp0_RData=0x11223344 at E2-E3, Err=0.
REQ-033 Both Valid every cycle, single ops -> grants alternate 0,1,0,1 starting with port 0; each port gets one response per turn.
REQ-034 Req1 lh at 0x21, then lw at 0xFE -> Rsp1_Err=1 one cycle after acceptance for each; MemRead/MemWrite never assert.
REQ-035 sb 0x80 to 0x30, then lb and lbu from 0x30 -> RData 0xFFFFFF80 and 0x00000080 respectively.
REQ-036 rst_n low during WAIT -> all outputs 0 asynchronously, no Rsp pulse; post-reset tie grants port 0.
REQ-037 Op=011 from Req0 -> Err response, no memory strobe, LastGrant=0.

Source files
------------

// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: two-port round-robin arbiter in front of a single DataMemory.
// Accepts one load/store at a time, checks it for a legal op, natural alignment
// and bounds, drives a one-cycle registered memory strobe and returns a one-cycle
// response pulse on the port that issued the request.
//
// Ports:
//   clk, rst_n                         clock, asynchronous active-low reset
//   ReqN_Valid / ReqN_Ready            request handshake, N = 0, 1
//   ReqN_Write, ReqN_Op                1 = store; MemOp encoding (lb/lh/lw/lbu/lhu)
//   ReqN_Addr, ReqN_WData              byte address and store data
//   RspN_Valid, RspN_RData, RspN_Err   response pulse, load data, error flag
//   MemOp, DataAddr, WriteData         registered DataMemory access fields
//   MemRead, MemWrite                  registered one-cycle DataMemory strobes
//   MemReadDataOut                     DataMemory read data, valid the cycle after the access
module data_mem_arbiter #(
    parameter int unsigned MEM_BYTES = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        Req0_Valid,
    output logic        Req0_Ready,
    input  logic        Req0_Write,
    input  logic [2:0]  Req0_Op,
    input  logic [31:0] Req0_Addr,
    input  logic [31:0] Req0_WData,
    input  logic        Req1_Valid,
    output logic        Req1_Ready,
    input  logic        Req1_Write,
    input  logic [2:0]  Req1_Op,
    input  logic [31:0] Req1_Addr,
    input  logic [31:0] Req1_WData,
    output logic        Rsp0_Valid,
    output logic [31:0] Rsp0_RData,
    output logic        Rsp0_Err,
    output logic        Rsp1_Valid,
    output logic [31:0] Rsp1_RData,
    output logic        Rsp1_Err,
    output logic [2:0]  MemOp,
    output logic [31:0] DataAddr,
    output logic [31:0] WriteData,
    output logic        MemRead,
    output logic        MemWrite,
    input  logic [31:0] MemReadDataOut
);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

    state_e      state_q;
    logic        last_grant_q;
    logic        gnt_q;
    logic        write_q;
    logic [1:0]  rsp_valid_q;
    logic [1:0]  rsp_err_q;
    logic [31:0] rdata_q;
    logic [2:0]  mem_op_q;
    logic [31:0] data_addr_q;
    logic [31:0] write_data_q;
    logic        mem_read_q;
    logic        mem_write_q;

    logic        sel;        // 1 selects port 1
    logic        accept;
    logic        sel_write;
    logic [2:0]  sel_op;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
    logic [2:0]  acc_bytes;
    logic        op_ok;
    logic        align_ok;
    logic [32:0] end_addr;   // one extra bit so addresses near 2^32 cannot wrap
    logic        req_err;

    always_comb begin
        // On a tie the port that did not win last time gets the grant.
        sel       = Req1_Valid && (!Req0_Valid || !last_grant_q);
        accept    = (state_q == StIdle) && (Req0_Valid || Req1_Valid);
        sel_write = sel ? Req1_Write : Req0_Write;
        sel_op    = sel ? Req1_Op    : Req0_Op;
        sel_addr  = sel ? Req1_Addr  : Req0_Addr;
        sel_wdata = sel ? Req1_WData : Req0_WData;

        acc_bytes = 3'd4;
        op_ok     = 1'b0;
        case (sel_op)
            3'b000, 3'b100: begin acc_bytes = 3'd1; op_ok = 1'b1; end
            3'b001, 3'b101: begin acc_bytes = 3'd2; op_ok = 1'b1; end
            3'b010:         begin acc_bytes = 3'd4; op_ok = 1'b1; end
            default:        begin acc_bytes = 3'd4; op_ok = 1'b0; end
        endcase

        if (acc_bytes == 3'd2) begin
            align_ok = !sel_addr[0];
        end else if (acc_bytes == 3'd4) begin
            align_ok = (sel_addr[1:0] == 2'b00);
        end else begin
            align_ok = 1'b1;
        end

        end_addr = {1'b0, sel_addr} + {30'b0, acc_bytes};
        req_err  = !op_ok || !align_ok || (end_addr > 33'(MEM_BYTES));

        // Ready is combinational from Valid, so reset must mask it directly.
        Req0_Ready = rst_n && accept && !sel;
        Req1_Ready = rst_n && accept && sel;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            last_grant_q <= 1'b1;
            gnt_q        <= 1'b0;
            write_q      <= 1'b0;
            rsp_valid_q  <= 2'b00;
            rsp_err_q    <= 2'b00;
            rdata_q      <= '0;
            mem_op_q     <= '0;
            data_addr_q  <= '0;
            write_data_q <= '0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (accept) begin
                        last_grant_q <= sel;
                        gnt_q        <= sel;
                        write_q      <= sel_write;
                        rdata_q      <= '0;
                        if (req_err) begin
                            // Errored requests never touch the memory bus.
                            state_q          <= StResp;
                            rsp_valid_q[sel] <= 1'b1;
                            rsp_err_q[sel]   <= 1'b1;
                        end else begin
                            state_q      <= StIssue;
                            mem_op_q     <= sel_op;
                            data_addr_q  <= sel_addr;
                            write_data_q <= sel_wdata;
                            mem_read_q   <= !sel_write;
                            mem_write_q  <= sel_write;
                        end
                    end
                end
                StIssue: begin
                    mem_read_q  <= 1'b0;
                    mem_write_q <= 1'b0;
                    if (write_q) begin
                        state_q            <= StResp;
                        rsp_valid_q[gnt_q] <= 1'b1;
                    end else begin
                        state_q <= StWait;
                    end
                end
                StWait: begin
                    rdata_q            <= MemReadDataOut;
                    state_q            <= StResp;
                    rsp_valid_q[gnt_q] <= 1'b1;
                end
                StResp: begin
                    rsp_valid_q <= 2'b00;
                    rsp_err_q   <= 2'b00;
                    state_q     <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign Rsp0_Valid = rsp_valid_q[0];
    assign Rsp1_Valid = rsp_valid_q[1];
    assign Rsp0_Err   = rsp_err_q[0];
    assign Rsp1_Err   = rsp_err_q[1];
    assign Rsp0_RData = gnt_q ? 32'h0 : rdata_q;
    assign Rsp1_RData = gnt_q ? rdata_q : 32'h0;
    assign MemOp      = mem_op_q;
    assign DataAddr   = data_addr_q;
    assign WriteData  = write_data_q;
    assign MemRead    = mem_read_q;
    assign MemWrite   = mem_write_q;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb_data_mem_arbiter: randomized + directed bench for data_mem_arbiter.
// A transaction-level model predicts grants, responses, latencies and memory
// strobes; a negedge monitor compares the DUT against it every cycle.
module tb_data_mem_arbiter;

    localparam int unsigned MEM_BYTES = 256;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid [2];
    logic        req_write [2];
    logic [2:0]  req_op    [2];
    logic [31:0] req_addr  [2];
    logic [31:0] req_wdata [2];
    logic        rdy0, rdy1, rsp_v0, rsp_v1, rsp_e0, rsp_e1;
    logic [31:0] rsp_d0, rsp_d1;
    logic [2:0]  mem_op;
    logic [31:0] data_addr, write_data, mem_rdata;
    logic        mem_read, mem_write;

    data_mem_arbiter #(.MEM_BYTES(MEM_BYTES)) dut (
        .clk(clk), .rst_n(rst_n),
        .Req0_Valid(req_valid[0]), .Req0_Ready(rdy0), .Req0_Write(req_write[0]),
        .Req0_Op(req_op[0]), .Req0_Addr(req_addr[0]), .Req0_WData(req_wdata[0]),
        .Req1_Valid(req_valid[1]), .Req1_Ready(rdy1), .Req1_Write(req_write[1]),
        .Req1_Op(req_op[1]), .Req1_Addr(req_addr[1]), .Req1_WData(req_wdata[1]),
        .Rsp0_Valid(rsp_v0), .Rsp0_RData(rsp_d0), .Rsp0_Err(rsp_e0),
        .Rsp1_Valid(rsp_v1), .Rsp1_RData(rsp_d1), .Rsp1_Err(rsp_e1),
        .MemOp(mem_op), .DataAddr(data_addr), .WriteData(write_data),
        .MemRead(mem_read), .MemWrite(mem_write), .MemReadDataOut(mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t        exp_q0[$];
    exp_t        exp_q1[$];
    int          n_checks = 0;
    int          n_err = 0;

    // Model state
    int          cyc = 0;
    int          free_cyc = 0;
    logic        last_m = 1'b1;
    int          acc_cnt [2] = '{0, 0};
    int          strobe_cyc = -1;
    logic        strobe_wr = 1'b0;
    logic [2:0]  m_op = '0;
    logic [31:0] m_addr = '0;
    logic [31:0] m_wd = '0;
    logic [7:0]  ref_mem [MEM_BYTES];
    logic [7:0]  env_mem [MEM_BYTES];

    // Driver state
    logic        pend_v [2] = '{1'b0, 1'b0};
    logic        pend_w [2];
    logic [2:0]  pend_op [2];
    logic [31:0] pend_addr [2];
    logic [31:0] pend_wd [2];
    int          seen [2] = '{0, 0};

    function automatic logic [7:0] init_byte(input int i);
        return 8'(i * 37 + 11) ^ 8'h5A;
    endfunction

    function automatic int grant_of(input logic v0, input logic v1, input logic last);
        if (v0 && v1) return last ? 0 : 1;
        return v1 ? 1 : 0;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    // Reference model: decides acceptance and predicts the whole transaction.
    task automatic accept_model(input int p);
        exp_t        e;
        int          size;
        logic        op_ok;
        logic [31:0] v;
        logic [2:0]  op;
        logic [31:0] a;
        int          lat;
        op = req_op[p];
        a  = req_addr[p];
        op_ok = (op == 3'd0) || (op == 3'd1) || (op == 3'd2) || (op == 3'd4) || (op == 3'd5);
        size = (op[1:0] == 2'd0) ? 1 : (op[1:0] == 2'd1) ? 2 : 4;
        e.err = !op_ok || ((a % size) != 0) || (longint'(a) + size > longint'(MEM_BYTES));
        e.rdata = '0;
        if (e.err) begin
            lat = 0;
        end else if (req_write[p]) begin
            lat = 1;
            for (int i = 0; i < size; i++) ref_mem[a + i] = req_wdata[p][8*i +: 8];
        end else begin
            lat = 2;
            v = '0;
            for (int i = 0; i < size; i++) v[8*i +: 8] = ref_mem[a + i];
            if (!op[2] && size == 1 && v[7]) v = v | 32'hFFFF_FF00;
            if (!op[2] && size == 2 && v[15]) v = v | 32'hFFFF_0000;
            e.rdata = v;
        end
        e.cyc = cyc + 1 + lat;
        free_cyc = e.cyc + 1;
        if (!e.err) begin
            strobe_cyc = cyc + 1;
            strobe_wr  = req_write[p];
            m_op = op;
            m_addr = a;
            m_wd = req_wdata[p];
        end
        last_m = (p == 1);
        acc_cnt[p]++;
        if (p == 0) exp_q0.push_back(e);
        else exp_q1.push_back(e);
    endtask

    initial begin
        for (int i = 0; i < MEM_BYTES; i++) ref_mem[i] = init_byte(i);
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                exp_q0.delete();
                exp_q1.delete();
                free_cyc = cyc;
                last_m = 1'b1;
                strobe_cyc = -1;
                m_op = '0;
                m_addr = '0;
                m_wd = '0;
            end else begin
                if (cyc >= free_cyc && (req_valid[0] || req_valid[1]))
                    accept_model(grant_of(req_valid[0], req_valid[1], last_m));
                cyc++;
            end
        end
    end

    // DataMemory stand-in: write at the strobe edge, extended read data one cycle later.
    initial begin
        logic [31:0] w;
        int          a;
        for (int i = 0; i < MEM_BYTES; i++) env_mem[i] = init_byte(i);
        mem_rdata = '0;
        forever begin
            @(posedge clk);
            a = int'(data_addr % MEM_BYTES);
            if (mem_write) begin
                for (int i = 0; i < ((mem_op[1:0] == 2'd0) ? 1 : (mem_op[1:0] == 2'd1) ? 2 : 4); i++)
                    env_mem[(a + i) % MEM_BYTES] = write_data[8*i +: 8];
            end
            if (mem_read) begin
                for (int i = 0; i < 4; i++) w[8*i +: 8] = env_mem[(a + i) % MEM_BYTES];
                case (mem_op)
                    3'b000:  mem_rdata <= {{24{w[7]}}, w[7:0]};
                    3'b100:  mem_rdata <= {24'h0, w[7:0]};
                    3'b001:  mem_rdata <= {{16{w[15]}}, w[15:0]};
                    3'b101:  mem_rdata <= {16'h0, w[15:0]};
                    default: mem_rdata <= w;
                endcase
            end
        end
    end

    task automatic rsp_check(input int p, input logic v, input logic [31:0] d, input logic er);
        exp_t e;
        int   n;
        n = (p == 0) ? exp_q0.size() : exp_q1.size();
        if (v) begin
            if (n == 0) begin
                chk($sformatf("rsp%0d_unexpected", p), 32'(v), 32'h0);
            end else begin
                if (p == 0) e = exp_q0.pop_front();
                else e = exp_q1.pop_front();
                chk($sformatf("rsp%0d_rdata", p), d, e.rdata);
                chk($sformatf("rsp%0d_err", p), 32'(er), 32'(e.err));
                chk($sformatf("rsp%0d_cycle", p), 32'(cyc), 32'(e.cyc));
            end
        end else if (n > 0) begin
            e = (p == 0) ? exp_q0[0] : exp_q1[0];
            if (e.cyc <= cyc) begin
                chk($sformatf("rsp%0d_missing", p), 32'(v), 32'h1);
                if (p == 0) void'(exp_q0.pop_front());
                else void'(exp_q1.pop_front());
            end
        end
    endtask

    // Monitor: mid-cycle comparison of every DUT output against the model.
    initial begin
        logic idle;
        int   g;
        forever begin
            @(negedge clk);
            idle = rst_n && (cyc >= free_cyc);
            g = grant_of(req_valid[0], req_valid[1], last_m);
            chk("ready0", 32'(rdy0), 32'(idle && req_valid[0] && g == 0));
            chk("ready1", 32'(rdy1), 32'(idle && req_valid[1] && g == 1));
            chk("memread", 32'(mem_read), 32'(rst_n && cyc == strobe_cyc && !strobe_wr));
            chk("memwrite", 32'(mem_write), 32'(rst_n && cyc == strobe_cyc && strobe_wr));
            chk("memop", 32'(mem_op), 32'(m_op));
            chk("dataaddr", data_addr, m_addr);
            chk("writedata", write_data, m_wd);
            rsp_check(0, rsp_v0, rsp_d0, rsp_e0);
            rsp_check(1, rsp_v1, rsp_d1, rsp_e1);
        end
    end

    task automatic apply();
        for (int p = 0; p < 2; p++) begin
            req_valid[p] = pend_v[p];
            req_write[p] = pend_w[p];
            req_op[p]    = pend_op[p];
            req_addr[p]  = pend_addr[p];
            req_wdata[p] = pend_wd[p];
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        for (int p = 0; p < 2; p++) begin
            if (seen[p] != acc_cnt[p]) begin
                seen[p] = acc_cnt[p];
                pend_v[p] = 1'b0;
            end
        end
        apply();
    endtask

    task automatic issue(input int p, input logic w, input logic [2:0] op,
                         input logic [31:0] a, input logic [31:0] wd);
        pend_w[p] = w;
        pend_op[p] = op;
        pend_addr[p] = a;
        pend_wd[p] = wd;
        pend_v[p] = 1'b1;
        apply();
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((pend_v[0] || pend_v[1] || exp_q0.size() > 0 || exp_q1.size() > 0 ||
                cyc < free_cyc) && n < 300) begin
            tick();
            n++;
        end
        if (n >= 300) chk("idle_timeout", 32'(n), 32'h0);
    endtask

    task automatic rand_txn(input int p);
        logic [2:0]  ops [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        logic [2:0]  op;
        logic [31:0] a;
        int          r;
        r = $urandom_range(0, 11);
        op = (r < 10) ? ops[r % 5] : 3'($urandom_range(0, 7));
        r = $urandom_range(0, 9);
        if (r == 0) a = $urandom;
        else a = 32'($urandom_range(0, MEM_BYTES + 3));
        if (r > 3) a = (op[1:0] == 2'd2) ? {a[31:2], 2'b00} : (op[1:0] == 2'd1) ? {a[31:1], 1'b0} : a;
        issue(p, 1'($urandom_range(0, 1)), op, a, $urandom);
    endtask

    initial begin
        for (int p = 0; p < 2; p++) begin
            pend_w[p] = 1'b0; pend_op[p] = '0; pend_addr[p] = '0; pend_wd[p] = '0;
        end
        apply();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        tick();

        // Store then load of a word
        issue(0, 1'b1, 3'b010, 32'h10, 32'h1122_3344); wait_idle();
        issue(0, 1'b0, 3'b010, 32'h10, 32'hDEAD_BEEF); wait_idle();
        // Byte store, then signed and unsigned byte loads
        issue(0, 1'b1, 3'b000, 32'h30, 32'h0000_0080); wait_idle();
        issue(0, 1'b0, 3'b000, 32'h30, 32'h0);         wait_idle();
        issue(0, 1'b0, 3'b100, 32'h30, 32'h0);         wait_idle();
        // Misaligned halfword and out-of-range word from port 1
        issue(1, 1'b0, 3'b001, 32'h21, 32'h0); wait_idle();
        issue(1, 1'b0, 3'b010, 32'hFE, 32'h0); wait_idle();
        // Illegal op from port 0, then a tie must go to port 1
        issue(0, 1'b0, 3'b011, 32'h40, 32'h0); wait_idle();
        issue(0, 1'b0, 3'b010, 32'h44, 32'h0);
        issue(1, 1'b0, 3'b010, 32'h48, 32'h0); wait_idle();
        // Both ports requesting continuously
        for (int k = 0; k < 40; k++) begin
            for (int p = 0; p < 2; p++) if (!pend_v[p]) issue(p, k[0], 3'b010, 32'(4 * (k % 60)), $urandom);
            tick();
        end
        wait_idle();

        // Reset during WAIT of a load
        issue(0, 1'b0, 3'b010, 32'h10, 32'h0);
        for (int n = 0; n < 10 && pend_v[0]; n++) tick();
        tick();
        issue(0, 1'b0, 3'b010, 32'h20, 32'h0);
        issue(1, 1'b0, 3'b010, 32'h24, 32'h0);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_ready0", 32'(rdy0), 32'h0);
        chk("rst_ready1", 32'(rdy1), 32'h0);
        chk("rst_rspv", {30'h0, rsp_v1, rsp_v0}, 32'h0);
        chk("rst_rspe", {30'h0, rsp_e1, rsp_e0}, 32'h0);
        chk("rst_rdata0", rsp_d0, 32'h0);
        chk("rst_rdata1", rsp_d1, 32'h0);
        chk("rst_strobes", {30'h0, mem_read, mem_write}, 32'h0);
        chk("rst_memop", 32'(mem_op), 32'h0);
        chk("rst_addr", data_addr, 32'h0);
        chk("rst_wdata", write_data, 32'h0);
        tick();
        tick();
        rst_n = 1'b1;
        wait_idle();

        // Randomized traffic with occasional withdrawn requests
        for (int k = 0; k < 1500; k++) begin
            for (int p = 0; p < 2; p++) begin
                if (!pend_v[p] && $urandom_range(0, 2) == 0) rand_txn(p);
                else if (pend_v[p] && $urandom_range(0, 15) == 0) begin
                    pend_v[p] = 1'b0;
                    apply();
                end
            end
            tick();
        end
        wait_idle();
        repeat (3) tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

    initial begin
        #500000;
        n_err++;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected completion");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
